// File: rtl/winograd_tile_loader_pkg.sv
// Shared definitions for the Winograd tile loader and the ALU-side unpacker:
// bank geometry defaults, FSM encoding and the write-index to slot mapping.
package winograd_tile_loader_pkg;

    localparam int NUM_SLOTS_DEF = 14;
    localparam int DATA_W_DEF    = 32;
    localparam int DUP_SLOT_DEF  = 1;
    localparam int WPT_DEF       = NUM_SLOTS_DEF - 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Primary slot for write index k; write k==dup also lands in dup+1.
    function automatic int slot_of(input int k, input int dup);
        return (k <= dup) ? k : k + 1;
    endfunction

endpackage

// File: rtl/winograd_tile_loader.sv
// Sequential operand loader: one word per handshake into a slot bank with a
// duplicated slot, tile presented on a valid/ready handshake once complete.
module winograd_tile_loader
    import winograd_tile_loader_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DUP_SLOT  = DUP_SLOT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        flush,
    output logic                        tile_valid,
    input  logic                        tile_ready,
    output logic [NUM_SLOTS*DATA_W-1:0] tile_data,
    output logic [3:0]                  fill_count,
    output logic                        overrun
);

    localparam int         WPT    = NUM_SLOTS - 1;
    localparam logic [3:0] LAST_K = 4'(WPT - 1);

    state_e                              state_q, state_d;
    logic [3:0]                          fill_q, fill_d;
    logic [NUM_SLOTS-1:0][DATA_W-1:0]    bank_q, bank_d;
    logic                                overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        bank_d    = bank_q;
        overrun_d = overrun_q;
        if (flush) begin
            state_d   = ST_EMPTY;
            fill_d    = '0;
            bank_d    = '0;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY, ST_FILL: begin
                    if (wr_valid) begin
                        // fill_q is the write index k of the incoming word.
                        for (int s = 0; s < NUM_SLOTS; s++) begin
                            if (s == slot_of(int'(fill_q), DUP_SLOT) ||
                                (int'(fill_q) == DUP_SLOT && s == DUP_SLOT + 1))
                                bank_d[s] = wr_data;
                        end
                        fill_d  = fill_q + 4'd1;
                        state_d = (fill_q == LAST_K) ? ST_FULL : ST_FILL;
                    end
                end
                ST_FULL: begin
                    if (wr_valid)
                        overrun_d = 1'b1;
                    if (tile_ready) begin
                        state_d = ST_EMPTY;
                        fill_d  = '0;
                        bank_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    fill_d  = '0;
                    bank_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            fill_q    <= '0;
            bank_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            bank_q    <= bank_d;
            overrun_q <= overrun_d;
        end
    end

    // Handshake outputs decode from state alone so no input reaches an output.
    assign wr_ready   = (state_q != ST_FULL);
    assign tile_valid = (state_q == ST_FULL);
    assign tile_data  = bank_q;
    assign fill_count = fill_q;
    assign overrun    = overrun_q;

endmodule
